inst_fetch: RTL and testbench

- Fetch stage directly upstream of inst_memory.
- Holds the Beta PC, drives the byte address into instruction memory, and captures the returned 32-bit big-endian word into an instruction register (IR) for decode.
- Handles the valid/ready handshake to decode, redirects from execute (branch/JMP/ILLOP/XADR), interrupt injection, and the PC[31] supervisor-bit rules.

---
 rtl/beta_pkg.sv | 23 ++
 rtl/inst_fetch_if.sv | 25 ++
 rtl/inst_fetch_pc_next_mux.sv | 38 +++
 rtl/inst_fetch.sv | 102 ++++++++++
 tb/tb_inst_fetch.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/beta_pkg.sv
// Shared constants and types for the Beta fetch stage: redirect encodings,
// trap/interrupt vectors, injected instruction words and the fetch FSM state type.
package beta_pkg;

    localparam logic [1:0] SEL_BR    = 2'd0;
    localparam logic [1:0] SEL_JMP   = 2'd1;
    localparam logic [1:0] SEL_ILLOP = 2'd2;
    localparam logic [1:0] SEL_XADR  = 2'd3;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] IRQ_INST = 32'h77DF_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction memory port, IR hand-off to decode, redirects
// from execute and the interrupt request. master = fetch stage side.
interface inst_fetch_if;
    logic [31:0] imem_adr;
    logic [31:0] imem_data;
    logic        id_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        redirect;
    logic [1:0]  redirect_sel;
    logic [31:0] redirect_tgt;
    logic        irq;
    logic [31:0] pc;

    modport master (
        output imem_adr, ir, ir_pc, ir_valid, pc,
        input  imem_data, id_ready, redirect, redirect_sel, redirect_tgt, irq
    );

    modport slave (
        input  imem_adr, ir, ir_pc, ir_valid, pc,
        output imem_data, id_ready, redirect, redirect_sel, redirect_tgt, irq
    );
endinterface

// File: rtl/inst_fetch_pc_next_mux.sv
// Next-PC selection for the fetch stage, including the rule that the
// supervisor bit (pc[31]) may be cleared by JMP but never set by user code.
module pc_next_mux
    import beta_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] redirect_tgt,
    input  logic        irq_take,
    input  logic        fetch,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_next
);

    // Targets are word aligned, so the low two target bits never reach pc.
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^redirect_tgt[1:0];

    always_comb begin
        // Increment stays inside bits [30:0] so the supervisor bit survives a wrap.
        pc_plus4 = {pc[31], pc[30:0] + 31'd4};
        pc_next  = pc;
        if (redirect) begin
            case (redirect_sel)
                SEL_BR:    pc_next = {pc[31], redirect_tgt[30:2], 2'b00};
                SEL_JMP:   pc_next = {pc[31] & redirect_tgt[31], redirect_tgt[30:2], 2'b00};
                SEL_ILLOP: pc_next = ILLOP_VEC;
                default:   pc_next = XADR_VEC;
            endcase
        end else if (irq_take) begin
            pc_next = XADR_VEC;
        end else if (fetch) begin
            pc_next = pc_plus4;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Beta fetch stage: PC register, IR capture with valid/ready to decode,
// redirects, interrupt injection. Define IFETCH_PERF_CNT_EN for perf counters.
module inst_fetch
    import beta_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    inst_fetch_if.master  bus
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetch,
    output logic [31:0]   perf_stall
`endif
);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] ir_reg;
    logic [31:0] ir_pc_reg;
    logic        ir_valid_reg;

    logic        adv;
    logic        redirect_take;
    logic        irq_take;
    logic        fetch;
    logic        stall;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;

    // The BOOT cycle ignores everything; after it, redirects win over irq and fetch.
    always_comb begin
        adv           = (state_reg != BOOT) && (!ir_valid_reg || bus.id_ready);
        redirect_take = (state_reg != BOOT) && bus.redirect;
        irq_take      = adv && bus.irq && !pc_reg[31] && !redirect_take;
        fetch         = adv && !redirect_take && !irq_take;
        stall         = (state_reg != BOOT) && ir_valid_reg && !bus.id_ready && !redirect_take;
        state_next    = stall ? STALL : RUN;
    end

    pc_next_mux u_pc_next_mux (
        .pc           (pc_reg),
        .redirect     (redirect_take),
        .redirect_sel (bus.redirect_sel),
        .redirect_tgt (bus.redirect_tgt),
        .irq_take     (irq_take),
        .fetch        (fetch),
        .pc_plus4     (pc_plus4),
        .pc_next      (pc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_VEC;
            ir_reg       <= NOP_INST;
            ir_pc_reg    <= 32'h0;
            ir_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (redirect_take) begin
                // Squash the wrong-path instruction; ir_pc keeps its last value.
                ir_reg       <= NOP_INST;
                ir_valid_reg <= 1'b0;
            end else if (irq_take) begin
                ir_reg       <= IRQ_INST;
                ir_pc_reg    <= pc_plus4;
                ir_valid_reg <= 1'b1;
            end else if (fetch) begin
                ir_reg       <= bus.imem_data;
                ir_pc_reg    <= pc_plus4;
                ir_valid_reg <= 1'b1;
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_reg;
    logic [31:0] perf_stall_reg;

    // A stall cycle is one where a live IR is held because decode is not ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_reg <= 32'h0;
            perf_stall_reg <= 32'h0;
        end else begin
            if (irq_take || fetch) perf_fetch_reg <= perf_fetch_reg + 32'd1;
            if (stall)             perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_fetch = perf_fetch_reg;
    assign perf_stall = perf_stall_reg;
`endif

    assign bus.imem_adr = {1'b0, pc_reg[30:0]};
    assign bus.ir       = ir_reg;
    assign bus.ir_pc    = ir_pc_reg;
    assign bus.ir_valid = ir_valid_reg;
    assign bus.pc       = pc_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Table-driven bench for inst_fetch: per-cycle vectors with hand-computed
// expectations; memory returns {16'hC0DE, adr[15:0]} for every address.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    inst_fetch_if bus ();

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    inst_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    assign bus.imem_data = {16'hC0DE, bus.imem_adr[15:0]};

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        rd;
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic        irq;
        logic [31:0] e_pc;
        logic [31:0] e_ir;
        logic [31:0] e_irpc;
        logic        e_v;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic rdy, logic rd, logic [1:0] sel,
                                logic [31:0] tgt, logic irq, logic [31:0] e_pc,
                                logic [31:0] e_ir, logic [31:0] e_irpc, logic e_v);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rd = rd; v.sel = sel; v.tgt = tgt; v.irq = irq;
        v.e_pc = e_pc; v.e_ir = e_ir; v.e_irpc = e_irpc; v.e_v = e_v;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic rdy, logic rd, logic [1:0] sel,
                         logic [31:0] tgt, logic irq);
        @(negedge clk);
        reset             = rst;
        bus.id_ready      = rdy;
        bus.redirect      = rd;
        bus.redirect_sel  = sel;
        bus.redirect_tgt  = tgt;
        bus.irq           = irq;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b1;
        bus.id_ready     = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_sel = 2'd0;
        bus.redirect_tgt = 32'h0;
        bus.irq          = 1'b0;

        //             rst rdy rd sel   tgt           irq   pc            ir            ir_pc         v
        vecs.push_back(mk(1, 1, 0, 2'd0, 32'h0,        0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 0)); // reset
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'h0,        0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 0)); // BOOT
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'h0,        0, 32'h8000_0004, 32'hC0DE_0000, 32'h8000_0004, 1)); // word@0
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'h0,        0, 32'h8000_0008, 32'hC0DE_0004, 32'h8000_0008, 1)); // word@4
        vecs.push_back(mk(0, 0, 0, 2'd0, 32'h0,        0, 32'h8000_0008, 32'hC0DE_0004, 32'h8000_0008, 1)); // stall 1
        vecs.push_back(mk(0, 0, 0, 2'd0, 32'h0,        0, 32'h8000_0008, 32'hC0DE_0004, 32'h8000_0008, 1)); // stall 2
        vecs.push_back(mk(0, 0, 0, 2'd0, 32'h0,        0, 32'h8000_0008, 32'hC0DE_0004, 32'h8000_0008, 1)); // stall 3
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'h0,        0, 32'h8000_000C, 32'hC0DE_0008, 32'h8000_000C, 1)); // release
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'h0,        0, 32'h8000_0010, 32'hC0DE_000C, 32'h8000_0010, 1));
        vecs.push_back(mk(0, 1, 1, 2'd1, 32'h0000_0123, 0, 32'h0000_0120, 32'h0000_0000, 32'h8000_0010, 0)); // JMP clears sup
        vecs.push_back(mk(0, 1, 1, 2'd1, 32'h8000_0200, 0, 32'h0000_0200, 32'h0000_0000, 32'h8000_0010, 0)); // JMP cannot set
        vecs.push_back(mk(0, 1, 1, 2'd0, 32'h0000_0040, 0, 32'h0000_0040, 32'h0000_0000, 32'h8000_0010, 0)); // BR user
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'h0,        1, 32'h8000_0008, 32'h77DF_0000, 32'h0000_0044, 1)); // irq taken
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'h0,        1, 32'h8000_000C, 32'hC0DE_0008, 32'h8000_000C, 1)); // irq masked
        vecs.push_back(mk(0, 1, 1, 2'd1, 32'h0000_003C, 0, 32'h0000_003C, 32'h0000_0000, 32'h8000_000C, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'h0,        0, 32'h0000_0040, 32'hC0DE_003C, 32'h0000_0040, 1));
        vecs.push_back(mk(0, 0, 1, 2'd0, 32'h0000_0100, 1, 32'h0000_0100, 32'h0000_0000, 32'h0000_0040, 0)); // redirect beats irq
        vecs.push_back(mk(0, 0, 0, 2'd0, 32'h0,        1, 32'h8000_0008, 32'h77DF_0000, 32'h0000_0104, 1)); // irq next cycle
        vecs.push_back(mk(0, 0, 0, 2'd0, 32'h0,        0, 32'h8000_0008, 32'h77DF_0000, 32'h0000_0104, 1)); // stall
        vecs.push_back(mk(1, 0, 0, 2'd0, 32'h0,        0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 0)); // reset mid-stall
        vecs.push_back(mk(1, 1, 1, 2'd3, 32'h0,        1, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 0)); // reset beats all
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'h0,        0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 0)); // BOOT
        vecs.push_back(mk(0, 1, 1, 2'd2, 32'h0000_0500, 0, 32'h8000_0004, 32'h0000_0000, 32'h0000_0000, 0)); // ILLOP
        vecs.push_back(mk(0, 1, 1, 2'd3, 32'h0000_0500, 0, 32'h8000_0008, 32'h0000_0000, 32'h0000_0000, 0)); // XADR
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'h0,        0, 32'h8000_000C, 32'hC0DE_0008, 32'h8000_000C, 1));
        vecs.push_back(mk(0, 1, 1, 2'd0, 32'h7FFF_FFFC, 0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h8000_000C, 0)); // BR keeps sup
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'h0,        0, 32'h8000_0000, 32'hC0DE_FFFC, 32'h8000_0000, 1)); // sup wrap
        vecs.push_back(mk(0, 1, 1, 2'd1, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFC, 32'h0000_0000, 32'h8000_0000, 0));
        vecs.push_back(mk(0, 1, 0, 2'd0, 32'h0,        0, 32'h0000_0000, 32'hC0DE_FFFC, 32'h0000_0000, 1)); // user wrap

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rd, vecs[i].sel, vecs[i].tgt, vecs[i].irq);
            $display("vec %0d: pc=%08h ir=%08h ir_pc=%08h v=%0b adr=%08h",
                     i, bus.pc, bus.ir, bus.ir_pc, bus.ir_valid, bus.imem_adr);
            chk($sformatf("v%0d pc", i),       bus.pc,               vecs[i].e_pc);
            chk($sformatf("v%0d ir", i),       bus.ir,               vecs[i].e_ir);
            chk($sformatf("v%0d ir_pc", i),    bus.ir_pc,            vecs[i].e_irpc);
            chk($sformatf("v%0d ir_valid", i), {31'h0, bus.ir_valid}, {31'h0, vecs[i].e_v});
            chk($sformatf("v%0d imem_adr", i), bus.imem_adr,         {1'b0, vecs[i].e_pc[30:0]});
        end

`ifdef IFETCH_PERF_CNT_EN
        drive(1, 1, 0, 2'd0, 32'h0, 0);
        $display("perf after reset: fetch=%0d stall=%0d", perf_fetch, perf_stall);
        chk("perf_fetch reset", perf_fetch, 32'd0);
        chk("perf_stall reset", perf_stall, 32'd0);
        drive(0, 1, 0, 2'd0, 32'h0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 2'd0, 32'h0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 2'd0, 32'h0, 0);
        $display("perf after run: fetch=%0d stall=%0d", perf_fetch, perf_stall);
        chk("perf_fetch count", perf_fetch, 32'd5);
        chk("perf_stall count", perf_stall, 32'd3);
        drive(1, 0, 0, 2'd0, 32'h0, 0);
        $display("perf after re-reset: fetch=%0d stall=%0d", perf_fetch, perf_stall);
        chk("perf_fetch re-reset", perf_fetch, 32'd0);
        chk("perf_stall re-reset", perf_stall, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
